// File: rtl/instr_fetch.sv
// Instruction fetch sequencer: owns the PC, issues single-outstanding reads to
// program memory, buffers returned words and hands them to the decoder.
module instr_fetch #(
  parameter int                ADDR_W     = 16,
  parameter int                INSTR_W    = 18,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0,
  parameter int                FIFO_DEPTH = 2
) (
  input  logic               i_clk,
  input  logic               i_rst,
  output logic               o_memReq,
  output logic [0:ADDR_W-1]  o_memAddr,
  input  logic               i_memAck,
  input  logic [0:INSTR_W-1] i_memData,
  output logic               o_instrValid,
  output logic [0:INSTR_W-1] o_instruction,
  output logic [0:ADDR_W-1]  o_instrPC,
  input  logic               i_instrReady,
  input  logic               i_redirect,
  input  logic [0:ADDR_W-1]  i_redirectAddr
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DISCARD
  } state_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0]  req_addr_q, req_addr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [CNT_W-1:0]   count_after;
  logic               push;
  logic               pop;
  logic               room;

  logic [INSTR_W-1:0] fifo_instr_q [FIFO_DEPTH];
  logic [ADDR_W-1:0]  fifo_pc_q    [FIFO_DEPTH];

  always_comb begin
    push        = (state_q == S_WAIT) && i_memAck && !i_redirect;
    pop         = (count_q != '0) && i_instrReady;
    count_after = count_q + CNT_W'(push) - CNT_W'(pop);
    // Room for one more read once this cycle's push/pop have landed.
    room        = (count_after < CNT_W'(FIFO_DEPTH));

    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_addr_d = req_addr_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;

    if (i_redirect) begin
      fetch_pc_d = i_redirectAddr;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      case (state_q)
        S_WAIT:    state_d = i_memAck ? S_IDLE : S_DISCARD;
        S_DISCARD: state_d = i_memAck ? S_IDLE : S_DISCARD;
        default:   state_d = S_IDLE;
      endcase
    end else begin
      count_d = count_after;
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case (state_q)
        S_IDLE: begin
          if (room) begin
            state_d    = S_WAIT;
            req_addr_d = fetch_pc_q;
          end
        end
        S_WAIT: begin
          if (i_memAck) begin
            fetch_pc_d = fetch_pc_q + ADDR_W'(1);
            if (room) req_addr_d = fetch_pc_q + ADDR_W'(1);
            else      state_d    = S_IDLE;
          end
        end
        S_DISCARD: begin
          if (i_memAck) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= S_IDLE;
      fetch_pc_q <= RESET_PC;
      req_addr_q <= RESET_PC;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_addr_q <= req_addr_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // Buffer storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge i_clk) begin
    if (push && !i_rst) begin
      fifo_instr_q[wr_ptr_q] <= i_memData;
      fifo_pc_q[wr_ptr_q]    <= req_addr_q;
    end
  end

  assign o_memReq      = (state_q != S_IDLE);
  assign o_memAddr     = req_addr_q;
  assign o_instrValid  = (count_q != '0);
  assign o_instruction = o_instrValid ? fifo_instr_q[rd_ptr_q] : '0;
  assign o_instrPC     = o_instrValid ? fifo_pc_q[rd_ptr_q] : '0;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: a memory model answers requests, a scoreboard
// holds the words the fetcher should deliver, in order.
module tb_instr_fetch;
  localparam int ADDR_W  = 16;
  localparam int INSTR_W = 18;
  localparam int DEPTH   = 2;

  logic               clk = 1'b0;
  logic               i_rst = 1'b1;
  logic               o_memReq;
  logic [0:ADDR_W-1]  o_memAddr;
  logic               i_memAck = 1'b0;
  logic [0:INSTR_W-1] i_memData = '0;
  logic               o_instrValid;
  logic [0:INSTR_W-1] o_instruction;
  logic [0:ADDR_W-1]  o_instrPC;
  logic               i_instrReady = 1'b0;
  logic               i_redirect = 1'b0;
  logic [0:ADDR_W-1]  i_redirectAddr = '0;

  instr_fetch #(
    .ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .RESET_PC(16'h0000), .FIFO_DEPTH(DEPTH)
  ) dut (
    .i_clk(clk), .i_rst(i_rst),
    .o_memReq(o_memReq), .o_memAddr(o_memAddr),
    .i_memAck(i_memAck), .i_memData(i_memData),
    .o_instrValid(o_instrValid), .o_instruction(o_instruction), .o_instrPC(o_instrPC),
    .i_instrReady(i_instrReady), .i_redirect(i_redirect), .i_redirectAddr(i_redirectAddr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
  } item_t;

  item_t             sb[$];
  logic [ADDR_W-1:0] pop_log[$];

  int n_checks = 0;
  int n_fail = 0;
  int n_fetched = 0;
  int n_delivered = 0;
  int lat = 1;
  int wait_cnt = 0;
  logic spurious = 1'b0;
  logic discard = 1'b0;
  logic [ADDR_W-1:0] exp_pc = '0;

  logic               prev_req = 1'b0, prev_ack = 1'b0, prev_valid = 1'b0;
  logic               prev_ready = 1'b0, prev_redir = 1'b0;
  logic [ADDR_W-1:0]  prev_addr = '0, prev_pc = '0;
  logic [INSTR_W-1:0] prev_instr = '0;

  function automatic logic [INSTR_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
    return {2'b00, a} + 18'd1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle, entered and left at a falling edge.
  task automatic tick();
    logic ack;
    logic [ADDR_W-1:0] a;
    item_t e;
    a = o_memAddr;
    if (prev_req && !prev_ack) begin
      chk("req_hold", 32'(o_memReq), 32'd1);
      chk("addr_hold", 32'(a), 32'(prev_addr));
    end
    ack = 1'b0;
    if (o_memReq) begin
      if (wait_cnt + 1 >= lat) begin
        ack = 1'b1;
        wait_cnt = 0;
      end else begin
        wait_cnt++;
      end
    end else begin
      wait_cnt = 0;
    end
    if (spurious) ack = 1'b1;
    i_memAck  = ack;
    i_memData = !ack ? 18'h3FFFF : (o_memReq ? mem_word(a) : 18'h2AAAA);

    if (o_instrValid && i_instrReady) begin
      chk("word_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("instruction", 32'(o_instruction), 32'(e.instr));
        chk("instr_pc", 32'(o_instrPC), 32'(e.pc));
      end
      pop_log.push_back(o_instrPC);
      n_delivered++;
    end
    if (prev_valid && !prev_ready && !prev_redir) begin
      chk("stall_valid", 32'(o_instrValid), 32'd1);
      chk("stall_instr", 32'(o_instruction), 32'(prev_instr));
      chk("stall_pc", 32'(o_instrPC), 32'(prev_pc));
    end

    if (i_redirect) begin
      sb.delete();
      discard = o_memReq && !ack;
      exp_pc  = i_redirectAddr;
    end else if (o_memReq && ack) begin
      if (discard) begin
        discard = 1'b0;
      end else begin
        chk("fetch_addr", 32'(a), 32'(exp_pc));
        sb.push_back('{instr: mem_word(exp_pc), pc: exp_pc});
        exp_pc = exp_pc + 16'd1;
        n_fetched++;
        chk("fifo_no_overflow", 32'(sb.size() <= DEPTH), 32'd1);
      end
    end

    prev_req   = o_memReq;
    prev_ack   = ack;
    prev_addr  = a;
    prev_valid = o_instrValid;
    prev_ready = i_instrReady;
    prev_redir = i_redirect;
    prev_instr = o_instruction;
    prev_pc    = o_instrPC;
    @(negedge clk);
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    i_memAck = 1'b0;
    i_redirect = 1'b0;
    i_instrReady = 1'b0;
    @(negedge clk);
    @(negedge clk);
    i_rst = 1'b0;
    sb.delete();
    discard = 1'b0;
    exp_pc = 16'h0000;
    wait_cnt = 0;
    prev_req = 1'b0;
    prev_ack = 1'b0;
    prev_valid = 1'b0;
    prev_redir = 1'b0;
    chk("rst_memReq", 32'(o_memReq), 32'd0);
    chk("rst_memAddr", 32'(o_memAddr), 32'd0);
    chk("rst_valid", 32'(o_instrValid), 32'd0);
    chk("rst_instr", 32'(o_instruction), 32'd0);
    chk("rst_pc", 32'(o_instrPC), 32'd0);
  endtask

  initial begin
    int guard;
    int fa;
    int da;
    @(negedge clk);
    do_reset();

    // Zero-wait memory, decoder always ready; an ack with no request is ignored
    lat = 1;
    i_instrReady = 1'b1;
    spurious = 1'b1;
    tick();
    spurious = 1'b0;
    chk("spurious_ack_valid", 32'(o_instrValid), 32'd0);
    chk("first_req", 32'(o_memReq), 32'd1);
    chk("first_addr", 32'(o_memAddr), 32'd0);
    tick();
    chk("lat1_valid", 32'(o_instrValid), 32'd1);
    chk("lat1_instr", 32'(o_instruction), 32'h00001);
    chk("lat1_pc", 32'(o_instrPC), 32'd0);
    chk("b2b_addr", 32'(o_memAddr), 32'd1);
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk("b2b_req", 32'(o_memReq), 32'd1);
      chk("b2b_valid", 32'(o_instrValid), 32'd1);
      chk("b2b_pc", 32'(o_instrPC), 32'(k));
      chk("b2b_instr", 32'(o_instruction), 32'(k + 1));
    end

    // Three-cycle memory latency
    lat = 3;
    fa = n_fetched;
    da = n_delivered;
    repeat (30) tick();
    chk("lat3_fetches", 32'(n_fetched - fa), 32'd10);
    chk("lat3_delivered", 32'((n_delivered - da) >= 9 && (n_delivered - da) <= 11), 32'd1);

    // Reset while a read is outstanding, then a late ack
    guard = 0;
    while (!(o_memReq && wait_cnt == 1) && guard < 20) begin tick(); guard++; end
    chk("mid_txn_reached", 32'(guard < 20), 32'd1);
    do_reset();
    lat = 1;
    spurious = 1'b1;
    tick();
    spurious = 1'b0;
    chk("late_ack_valid", 32'(o_instrValid), 32'd0);
    chk("late_ack_req", 32'(o_memReq), 32'd1);
    chk("late_ack_addr", 32'(o_memAddr), 32'd0);

    // Decoder stalled: FIFO fills, then fetch stops
    i_instrReady = 1'b0;
    fa = n_fetched;
    repeat (10) tick();
    chk("stall_fetches", 32'(n_fetched - fa), 32'(DEPTH));
    chk("stall_req_low", 32'(o_memReq), 32'd0);
    chk("stall_head_pc", 32'(o_instrPC), 32'd0);
    chk("stall_head_instr", 32'(o_instruction), 32'h00001);
    i_instrReady = 1'b1;
    pop_log.delete();
    repeat (6) tick();
    chk("drain_count", 32'(pop_log.size() >= 3), 32'd1);
    if (pop_log.size() >= 3) begin
      chk("drain_pc0", 32'(pop_log[0]), 32'd0);
      chk("drain_pc1", 32'(pop_log[1]), 32'd1);
      chk("drain_pc2", 32'(pop_log[2]), 32'd2);
    end

    // Redirect while the read of address 5 is outstanding
    do_reset();
    i_instrReady = 1'b1;
    lat = 3;
    guard = 0;
    while (!(o_memReq && o_memAddr == 16'd5 && wait_cnt == 0) && guard < 60) begin tick(); guard++; end
    chk("addr5_reached", 32'(guard < 60), 32'd1);
    i_redirect = 1'b1;
    i_redirectAddr = 16'h0040;
    tick();
    i_redirect = 1'b0;
    chk("redir_flush_valid", 32'(o_instrValid), 32'd0);
    chk("discard_req", 32'(o_memReq), 32'd1);
    chk("discard_addr", 32'(o_memAddr), 32'd5);
    pop_log.delete();
    guard = 0;
    while (pop_log.size() == 0 && guard < 40) begin tick(); guard++; end
    chk("redir40_delivered", 32'(pop_log.size() != 0), 32'd1);
    if (pop_log.size() != 0) chk("redir40_first_pc", 32'(pop_log[0]), 32'h0040);

    // Redirect in the same cycle as an ack
    lat = 1;
    guard = 0;
    while (!o_memReq && guard < 10) begin tick(); guard++; end
    chk("req_for_ack_redir", 32'(o_memReq), 32'd1);
    i_redirect = 1'b1;
    i_redirectAddr = 16'h0100;
    tick();
    i_redirect = 1'b0;
    chk("ackredir_valid", 32'(o_instrValid), 32'd0);
    chk("ackredir_idle", 32'(o_memReq), 32'd0);
    tick();
    chk("ackredir_req", 32'(o_memReq), 32'd1);
    chk("ackredir_addr", 32'(o_memAddr), 32'h0100);
    pop_log.delete();
    repeat (3) tick();
    chk("ackredir_count", 32'(pop_log.size() != 0), 32'd1);
    if (pop_log.size() != 0) chk("ackredir_first_pc", 32'(pop_log[0]), 32'h0100);

    // PC wrap at the top of the address space
    i_redirect = 1'b1;
    i_redirectAddr = 16'hFFFF;
    tick();
    i_redirect = 1'b0;
    pop_log.delete();
    repeat (8) tick();
    chk("wrap_count", 32'(pop_log.size() >= 3), 32'd1);
    if (pop_log.size() >= 3) begin
      chk("wrap_pc0", 32'(pop_log[0]), 32'hFFFF);
      chk("wrap_pc1", 32'(pop_log[1]), 32'h0000);
      chk("wrap_pc2", 32'(pop_log[2]), 32'h0001);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
Instruction fetch sequencer that produces the 18-bit instruction words consumed by the CPU control unit's decoder. It owns the program counter and issues reads to program memory over a req/ack interface. Returned words are buffered in a small FIFO and presented to the decoder with a valid/ready handshake. Taken jumps from the execute stage are accepted as a redirect that flushes in-flight and buffered words.

Parameters:
ADDR_W, 16, program-counter / memory address width
INSTR_W, 18, instruction width; fixed at 18 for this CPU
RESET_PC, 0, fetch address loaded on reset
FIFO_DEPTH, 2, instruction buffer entries (power of two, >=2)

Ports:
i_clk  input  1  clock, all state updates on rising edge
i_rst  input  1  reset, synchronous and active-high
o_memReq  output  1  read request, held high until acknowledged
o_memAddr  output  [0:ADDR_W-1]  read address, stable while o_memReq high
i_memAck  input  1  read complete; i_memData valid this cycle
i_memData  input  [0:INSTR_W-1]  instruction word returned with ack
o_instrValid  output  1  o_instruction/o_instrPC valid
o_instruction  output  [0:INSTR_W-1]  instruction to the decoder
o_instrPC  output  [0:ADDR_W-1]  address the instruction was fetched from
i_instrReady  input  1  decoder accepts the word this cycle
i_redirect  input  1  taken jump: restart fetch at i_redirectAddr
i_redirectAddr  input  [0:ADDR_W-1]  jump target

Behaviour:
- Reset (i_rst high at an edge): fetchPC=RESET_PC, FIFO empty, state IDLE, o_memReq=0, o_memAddr=RESET_PC, o_instrValid=0, o_instruction=0, o_instrPC=0. Reset mid-transaction abandons the outstanding read; an ack arriving after reset is ignored (state IDLE with no request outstanding).
- At most one memory read outstanding. The request is a transaction: o_memReq rises with o_memAddr=fetchPC, and both are held until the cycle i_memAck=1. Ack may arrive in any cycle o_memReq is high, including the first. i_memAck while o_memReq=0 is ignored.
- Issue condition: occupancy + outstanding < FIFO_DEPTH, and i_redirect=0.
- FSM:
  IDLE: if the issue condition holds, raise o_memReq and go to WAIT.
  WAIT: on ack without redirect, push {i_memData, o_memAddr} and set fetchPC=fetchPC+1. If the issue condition still holds counting this push and any same-cycle pop, keep o_memReq high with the new address (back-to-back, one word per cycle sustained). Otherwise drop o_memReq and go to IDLE.
  DISCARD: entered on redirect while in WAIT without ack. Keep o_memReq and the old address held until ack, drop the returned data, then go to IDLE.
- Redirect has priority over every other event:
  - fetchPC becomes i_redirectAddr and the FIFO is flushed the same edge; o_instrValid=0 next cycle.
  - In WAIT with i_memAck in the same cycle, the data is dropped and the FSM goes to IDLE; the new fetch may start the next cycle.
  - In WAIT without ack, the FSM goes to DISCARD.
  - In DISCARD, a further redirect only updates fetchPC.
  - Any pop in the redirect cycle counts as consumed.
- FIFO: push on accepted ack, pop on o_instrValid & i_instrReady. Simultaneous push and pop are legal at any occupancy. Overflow is impossible by the issue rule; a violation is a bench assertion failure.
- Latency: ack to o_instrValid is 1 cycle when the FIFO is empty. Outputs come from the FIFO head and are registered.
- o_instruction and o_instrPC must hold stable while o_instrValid=1 and i_instrReady=0.
- fetchPC increment wraps from 2^ADDR_W-1 to 0. No other arithmetic is performed.

Test Plan:
- Reset, then memory acks on the first req cycle with data 18'h00001, 18'h00002, ...; i_instrReady=1 -> o_memAddr 0,1,2,... with req continuously high. o_instrValid first high 1 cycle after the first ack. o_instruction/o_instrPC = (1,0),(2,1),(3,2) on consecutive cycles.
- Ack latency of 3 cycles -> o_memAddr held 3 cycles per word. One instruction is delivered per 3 cycles with correct PCs and no duplicates.
- i_instrReady=0 for 10 cycles -> exactly FIFO_DEPTH words are fetched and o_memReq then stays low. Head word is stable throughout. Raising ready drains the words in order and fetching resumes.
- Redirect to 16'h0040 while a read of address 5 is outstanding (ack 2 cycles later) -> the address 5 data never appears and the FIFO is empty next cycle. The next request is to 16'h0040, and the first delivered o_instrPC is 16'h0040.
- Redirect to 16'h0100 in the same cycle as an ack -> the acked word is dropped and the next o_memAddr is 16'h0100.
- Redirect to 16'hFFFF -> delivered PCs are FFFF, then 0000, then 0001.
